uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (XMitGo/TxEmpty/TxData handshake) between NUM_REQ byte-stream requesters, such as message drivers, status reporters and debug dumpers.
- Grants are round-robin and packet-locked: a winner keeps the UART until it marks its last byte, drops its request, or hits the MAX_PKT fairness cap.
- Sits between the requester modules and the UART TX core.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side handshake bundle for uart_tx_arbiter.
// master = arbiter view, slave = requesters plus UART core view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   Req;
    logic [8*NUM_REQ-1:0] ReqData;
    logic [NUM_REQ-1:0]   ReqLast;
    logic [NUM_REQ-1:0]   ByteAck;
    logic [NUM_REQ-1:0]   Grant;
    logic                 TxEmpty;
    logic                 XMitGo;
    logic [7:0]           TxData;

    modport master (
        input  Req, ReqData, ReqLast, TxEmpty,
        output ByteAck, Grant, XMitGo, TxData
    );

    modport slave (
        output Req, ReqData, ReqLast, TxEmpty,
        input  ByteAck, Grant, XMitGo, TxData
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ requesters.
// Define TXARB_WATCHDOG_EN to add the SEND-state timeout and sticky WdogErr flag.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PKT     = 64,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic              Clock,
    input  logic              Reset,
    uart_tx_arbiter_if.master bus,
    output logic              Busy,
    output logic              WdogErr
);
    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_PKT < 1 || MAX_PKT > 255 ||
        WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        RELEASE
    } state_t;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      next_winner;
    logic               found;
    logic [7:0]         count;
    logic               lastq;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] byte_ack;
    logic               xmit_go;
    logic [7:0]         tx_data;
    logic               busy;

`ifdef TXARB_WATCHDOG_EN
    logic [15:0]        wdog_cnt;
    logic               wdog_err;
`endif

    // Scan upward from the requester after the last owner, wrapping at NUM_REQ.
    always_comb begin
        // NOTE: defaults first so no path through the loop leaves a latch behind.
        int sum;
        sum         = 0;
        found       = 1'b0;
        next_winner = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            if (!found && bus.Req[sum[IW-1:0]]) begin
                found       = 1'b1;
                next_winner = sum[IW-1:0];
            end
        end
    end

    // NOTE: state and outputs update with non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            ptr      <= IW'(NUM_REQ - 1);
            winner   <= '0;
            count    <= 8'd0;
            lastq    <= 1'b0;
            grant    <= '0;
            byte_ack <= '0;
            xmit_go  <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
`ifdef TXARB_WATCHDOG_EN
            wdog_cnt <= 16'd0;
            wdog_err <= 1'b0;
`endif
        end else begin
            byte_ack <= '0;
            case (state)
                IDLE: begin
                    if (found && bus.TxEmpty) begin
                        winner <= next_winner;
                        grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << next_winner;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (!bus.Req[winner]) begin
                        state <= RELEASE;
                    end else begin
                        tx_data <= bus.ReqData[int'(winner)*8 +: 8];
                        lastq   <= bus.ReqLast[winner];
                        xmit_go <= 1'b1;
                        count   <= count + 8'd1;
`ifdef TXARB_WATCHDOG_EN
                        wdog_cnt <= 16'd0;
`endif
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (!bus.TxEmpty) begin
                        xmit_go          <= 1'b0;
                        byte_ack[winner] <= 1'b1;
                        state <= (lastq || count == 8'(MAX_PKT)) ? RELEASE : GAP;
                    end
`ifdef TXARB_WATCHDOG_EN
                    else if (wdog_cnt == 16'(WDOG_CYCLES - 1)) begin
                        xmit_go  <= 1'b0;
                        wdog_err <= 1'b1;
                        state    <= RELEASE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 16'd1;
                    end
`endif
                end
                GAP: begin
                    if (bus.TxEmpty) state <= LOAD;
                end
                RELEASE: begin
                    ptr   <= winner;
                    grant <= '0;
                    count <= 8'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Grant   = grant;
    assign bus.ByteAck = byte_ack;
    assign bus.XMitGo  = xmit_go;
    assign bus.TxData  = tx_data;
    assign Busy        = busy;

`ifdef TXARB_WATCHDOG_EN
    assign WdogErr = wdog_err;
`else
    assign WdogErr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table of queued bytes with expected send slots,
// plus hand sequences for drop-out latency, reset in SEND and the optional watchdog.
module tb_uart_tx_arbiter;
    localparam int NR   = 4;
    localparam int MAXP = 4;
    localparam int WD   = 16;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic Busy;
    logic WdogErr;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (NR),
        .MAX_PKT    (MAXP),
        .WDOG_CYCLES(WD)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .bus    (bus.master),
        .Busy   (Busy),
        .WdogErr(WdogErr)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } qbyte_t;

    typedef struct {
        int         grp;
        int         src;
        logic [7:0] data;
        logic       last;
        int         slot;
    } vec_t;

    typedef struct {
        int         owner;
        logic [7:0] data;
    } sent_t;

    qbyte_t rq [NR][$];
    vec_t   vecs[$];
    sent_t  sent_log[$];

    int   checks = 0;
    int   errors = 0;
    int   ack_cnt[NR];
    int   xmit_rises;
    logic xmit_prev;
    logic uart_en = 1'b1;
    int   ucnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] g);
        int r = -1;
        int c = 0;
        for (int i = 0; i < NR; i++)
            if (g[i] === 1'b1) begin
                r = i;
                c++;
            end
        return (c == 1) ? r : -1;
    endfunction

    // Requester models: present the queue head, advance on ByteAck.
    always @(negedge Clock) begin
        for (int i = 0; i < NR; i++)
            if (bus.ByteAck[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                bus.Req[i]            = 1'b1;
                bus.ReqData[8*i +: 8] = rq[i][0].data;
                bus.ReqLast[i]        = rq[i][0].last;
            end else begin
                bus.Req[i]            = 1'b0;
                bus.ReqData[8*i +: 8] = 8'h00;
                bus.ReqLast[i]        = 1'b0;
            end
        end
    end

    // UART model: accept 2 clocks after XMitGo, busy for 10 clocks; logs owner and byte.
    always @(negedge Clock) begin
        if (Reset || !uart_en) begin
            bus.TxEmpty = 1'b1;
            ucnt        = 0;
            if (Reset) sent_log.delete();
        end else if (bus.TxEmpty) begin
            if (bus.XMitGo === 1'b1) begin
                ucnt++;
                if (ucnt == 2) begin
                    bus.TxEmpty = 1'b0;
                    ucnt        = 0;
                    sent_log.push_back('{owner: onehot_idx(bus.Grant), data: bus.TxData});
                end
            end else begin
                ucnt = 0;
            end
        end else begin
            ucnt++;
            if (ucnt == 10) begin
                bus.TxEmpty = 1'b1;
                ucnt        = 0;
            end
        end
    end

    always @(negedge Clock) begin
        if (Reset) begin
            xmit_rises = 0;
            for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
        end else begin
            if (bus.XMitGo === 1'b1 && xmit_prev !== 1'b1) xmit_rises++;
            for (int i = 0; i < NR; i++)
                if (bus.ByteAck[i] === 1'b1) ack_cnt[i]++;
        end
        xmit_prev = bus.XMitGo;
    end

    task automatic add_vec(input int g, input int s, input logic [7:0] d, input logic l, input int slot);
        vecs.push_back('{grp: g, src: s, data: d, last: l, slot: slot});
    endtask

    task automatic wait_idle(input int n, input string name);
        int cyc = 0;
        while (!(sent_log.size() >= n && Busy === 1'b0 && bus.TxEmpty === 1'b1) && cyc < 3000) begin
            @(negedge Clock);
            cyc++;
        end
        check(name, 32'(cyc < 3000), 32'd1);
    endtask

    task automatic start_group(input int g);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        check($sformatf("g%0d_rst_xmitgo", g), 32'(bus.XMitGo), 32'd0);
        check($sformatf("g%0d_rst_txdata", g), 32'(bus.TxData), 32'd0);
        check($sformatf("g%0d_rst_grant", g), 32'(bus.Grant), 32'd0);
        check($sformatf("g%0d_rst_byteack", g), 32'(bus.ByteAck), 32'd0);
        check($sformatf("g%0d_rst_busy", g), 32'(Busy), 32'd0);
        check($sformatf("g%0d_rst_wdogerr", g), 32'(WdogErr), 32'd0);
        for (int i = 0; i < NR; i++) rq[i].delete();
        foreach (vecs[k])
            if (vecs[k].grp == g) rq[vecs[k].src].push_back('{data: vecs[k].data, last: vecs[k].last});
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic finish_group(input int g);
        int n = 0;
        int s;
        int exp_ack;
        foreach (vecs[k]) if (vecs[k].grp == g) n++;
        wait_idle(n, $sformatf("g%0d_done", g));
        repeat (20) @(negedge Clock);
        check($sformatf("g%0d_bytes_sent", g), 32'(sent_log.size()), 32'(n));
        check($sformatf("g%0d_xmitgo_pulses", g), 32'(xmit_rises), 32'(n));
        check($sformatf("g%0d_grant_idle", g), 32'(bus.Grant), 32'd0);
        foreach (vecs[k]) begin
            if (vecs[k].grp == g) begin
                s = vecs[k].slot;
                check($sformatf("g%0d_slot%0d_owner", g, s),
                      (s < sent_log.size()) ? 32'(sent_log[s].owner) : 32'hFFFF_FFFF, 32'(vecs[k].src));
                check($sformatf("g%0d_slot%0d_data", g, s),
                      (s < sent_log.size()) ? 32'(sent_log[s].data) : 32'hFFFF_FFFF, 32'(vecs[k].data));
            end
        end
        for (int i = 0; i < NR; i++) begin
            exp_ack = 0;
            foreach (vecs[k]) if (vecs[k].grp == g && vecs[k].src == i) exp_ack++;
            check($sformatf("g%0d_byteack%0d_count", g, i), 32'(ack_cnt[i]), 32'(exp_ack));
        end
    endtask

    initial begin
        int cyc;
        int lat;
        int hi;

        // Group 1: single requester, 3-byte packet.
        add_vec(1, 0, 8'h48, 1'b0, 0);
        add_vec(1, 0, 8'h69, 1'b0, 1);
        add_vec(1, 0, 8'h0A, 1'b1, 2);
        // Group 2: all four requesting 1-byte packets -> 0,1,2,3,0,1.
        add_vec(2, 0, 8'hA0, 1'b1, 0);
        add_vec(2, 1, 8'hA1, 1'b1, 1);
        add_vec(2, 2, 8'hA2, 1'b1, 2);
        add_vec(2, 3, 8'hA3, 1'b1, 3);
        add_vec(2, 0, 8'hB0, 1'b1, 4);
        add_vec(2, 1, 8'hB1, 1'b1, 5);
        // Group 3: requester 1 streams 10 bytes with no last, capped at 4 per grant.
        add_vec(3, 1, 8'h10, 1'b0, 0);
        add_vec(3, 1, 8'h11, 1'b0, 1);
        add_vec(3, 1, 8'h12, 1'b0, 2);
        add_vec(3, 1, 8'h13, 1'b0, 3);
        add_vec(3, 1, 8'h14, 1'b0, 6);
        add_vec(3, 1, 8'h15, 1'b0, 7);
        add_vec(3, 1, 8'h16, 1'b0, 8);
        add_vec(3, 1, 8'h17, 1'b0, 9);
        add_vec(3, 1, 8'h18, 1'b0, 10);
        add_vec(3, 1, 8'h19, 1'b0, 11);
        add_vec(3, 2, 8'h20, 1'b0, 4);
        add_vec(3, 2, 8'h21, 1'b1, 5);
        // Group 4: requester 3 drops Req after its second byte.
        add_vec(4, 3, 8'h31, 1'b0, 0);
        add_vec(4, 3, 8'h32, 1'b0, 1);

        for (int g = 1; g <= 4; g++) begin
            start_group(g);
            if (g == 4) begin
                cyc = 0;
                while (ack_cnt[3] < 2 && cyc < 2000) begin
                    @(negedge Clock);
                    cyc++;
                end
                check("g4_second_ack_seen", 32'(ack_cnt[3] >= 2), 32'd1);
                cyc = 0;
                while (bus.TxEmpty !== 1'b1 && cyc < 100) begin
                    @(negedge Clock);
                    cyc++;
                end
                check("g4_txempty_back", 32'(bus.TxEmpty), 32'd1);
                lat = 0;
                while (bus.Grant !== '0 && lat < 10) begin
                    @(negedge Clock);
                    lat++;
                end
                check("g4_release_within_3", 32'(lat <= 3), 32'd1);
            end
            finish_group(g);
        end

        // Reset while XMitGo is high: pointer must restart at requester 0.
        start_group(5);
        rq[1].push_back('{data: 8'h11, last: 1'b1});
        wait_idle(1, "rst_pre_done");
        check("rst_pre_owner", (sent_log.size() > 0) ? 32'(sent_log[0].owner) : 32'hFFFF_FFFF, 32'd1);
        uart_en = 1'b0;
        rq[2].push_back('{data: 8'h22, last: 1'b1});
        cyc = 0;
        while (bus.XMitGo !== 1'b1 && cyc < 100) begin
            @(negedge Clock);
            cyc++;
        end
        check("rst_pre_xmitgo", 32'(bus.XMitGo), 32'd1);
        check("rst_pre_grant", 32'(bus.Grant), 32'b0100);
        Reset = 1'b1;
        @(negedge Clock);
        check("rst_mid_xmitgo", 32'(bus.XMitGo), 32'd0);
        check("rst_mid_grant", 32'(bus.Grant), 32'd0);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_byteack", 32'(bus.ByteAck), 32'd0);
        rq[1].push_back('{data: 8'h33, last: 1'b1});
        @(negedge Clock);
        Reset   = 1'b0;
        uart_en = 1'b1;
        wait_idle(2, "rst_post_done");
        check("rst_post_first_owner", (sent_log.size() > 0) ? 32'(sent_log[0].owner) : 32'hFFFF_FFFF, 32'd1);
        check("rst_post_first_data", (sent_log.size() > 0) ? 32'(sent_log[0].data) : 32'hFFFF_FFFF, 32'h33);
        check("rst_post_second_owner", (sent_log.size() > 1) ? 32'(sent_log[1].owner) : 32'hFFFF_FFFF, 32'd2);
        check("rst_post_second_data", (sent_log.size() > 1) ? 32'(sent_log[1].data) : 32'hFFFF_FFFF, 32'h22);
        check("rst_post_ack2_count", 32'(ack_cnt[2]), 32'd1);

`ifdef TXARB_WATCHDOG_EN
        uart_en = 1'b0;
        rq[0].push_back('{data: 8'h55, last: 1'b1});
        cyc = 0;
        while (bus.XMitGo !== 1'b1 && cyc < 100) begin
            @(negedge Clock);
            cyc++;
        end
        check("wdog_xmitgo_rise", 32'(bus.XMitGo), 32'd1);
        rq[0].delete();
        hi = 1;
        @(negedge Clock);
        while (bus.XMitGo === 1'b1 && hi < 200) begin
            hi++;
            @(negedge Clock);
        end
        check("wdog_xmitgo_cycles", 32'(hi), 32'(WD));
        check("wdog_err_set", 32'(WdogErr), 32'd1);
        cyc = 0;
        while (Busy !== 1'b0 && cyc < 100) begin
            @(negedge Clock);
            cyc++;
        end
        check("wdog_back_idle", 32'(Busy), 32'd0);
        check("wdog_no_byteack", 32'(ack_cnt[0]), 32'd0);
        check("wdog_err_sticky", 32'(WdogErr), 32'd1);
`else
        check("wdog_err_tied_low", 32'(WdogErr), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
